// File: rtl/mips_bus_pkg.sv
// Shared encodings and the tie-break picker for the two-master MIPS bus arbiter.
// State encodings deliberately match the grant encodings so ownership maps 1:1 onto grant.
package mips_bus_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'b00;
  localparam state_t ST_OWN_M0 = 2'b01;
  localparam state_t ST_OWN_M1 = 2'b10;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  localparam logic [31:0] MEM_BASE = 32'hBFC00000;

  // Choose the next owner from IDLE; on a tie, fair mode favours whoever did not own last.
  function automatic state_t pick_owner(input logic m0_req, input logic m1_req,
                                        input logic fair, input logic last_owner);
    state_t pick;
    if (m0_req && m1_req) begin
      if (fair) pick = (last_owner == OWNER_M1) ? ST_OWN_M0 : ST_OWN_M1;
      else      pick = ST_OWN_M1;
    end else if (m0_req) begin
      pick = ST_OWN_M0;
    end else if (m1_req) begin
      pick = ST_OWN_M1;
    end else begin
      pick = ST_IDLE;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mips_bus_arbiter.sv
// Arbitrates an instruction-fetch master (M0) and a data master (M1) onto one memory slave.
// Request fields are muxed straight through from the owner; nothing is latched.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int unsigned FAIR = 1
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,

  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,

  output logic [31:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_byteenable,
  input  logic        s_waitrequest,
  input  logic [31:0] s_readdata,

  output logic [1:0]  grant
);

  state_t state_q, state_d;
  logic   last_q, last_d;
  // Holds off arbitration for the first edge after reset release.
  logic   arb_en_q;

  logic m0_req, m1_req;
  logic fair_mode;

  assign m0_req    = m0_read | m0_write;
  assign m1_req    = m1_read | m1_write;
  assign fair_mode = (FAIR != 0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      last_q   <= OWNER_M1;
      arb_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      arb_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_en_q) state_d = pick_owner(m0_req, m1_req, fair_mode, last_q);
      end
      ST_OWN_M0: begin
        // Dropping both strobes mid-stall is an abort, not a completion.
        if (!m0_req) begin
          state_d = ST_IDLE;
        end else if (!s_waitrequest) begin
          last_d  = OWNER_M0;
          state_d = m1_req ? ST_OWN_M1 : ST_IDLE;
        end
      end
      ST_OWN_M1: begin
        if (!m1_req) begin
          state_d = ST_IDLE;
        end else if (!s_waitrequest) begin
          last_d  = OWNER_M1;
          state_d = m0_req ? ST_OWN_M0 : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_address      = 32'h0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = 32'h0;
    s_byteenable   = 4'h0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    grant          = GNT_NONE;
    case (state_q)
      ST_OWN_M0: begin
        s_address      = m0_address;
        s_read         = m0_read;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest;
        grant          = GNT_M0;
      end
      ST_OWN_M1: begin
        s_address      = m1_address;
        s_read         = m1_read;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest;
        grant          = GNT_M1;
      end
      default: ;
    endcase
  end

  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: a round-robin instance plus a fixed-priority instance
// sharing the same stimulus; the fixed-priority one is only checked on the post-reset tie.
module tb_mips_bus_arbiter;
  import mips_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] m0_address, m0_writedata, m1_address, m1_writedata, s_readdata;
  logic        m0_read, m0_write, m1_read, m1_write, s_waitrequest;
  logic [3:0]  m0_byteenable, m1_byteenable;

  logic        m0_waitrequest, m1_waitrequest, s_read, s_write;
  logic [31:0] m0_readdata, m1_readdata, s_address, s_writedata;
  logic [3:0]  s_byteenable;
  logic [1:0]  grant;

  logic        fp_m0_wait, fp_m1_wait, fp_s_read, fp_s_write;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_address, fp_s_wdata;
  logic [3:0]  fp_s_be;
  logic [1:0]  fp_grant;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mips_bus_arbiter #(.FAIR(1)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .grant(grant)
  );

  mips_bus_arbiter #(.FAIR(0)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(fp_m0_wait), .m0_readdata(fp_m0_rdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(fp_m1_wait), .m1_readdata(fp_m1_rdata),
    .s_address(fp_s_address), .s_read(fp_s_read), .s_write(fp_s_write),
    .s_writedata(fp_s_wdata), .s_byteenable(fp_s_be),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .grant(fp_grant)
  );

  task automatic clear_inputs();
    m0_address = 32'h0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = 32'h0;
    m0_byteenable = 4'h0;
    m1_address = 32'h0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = 32'h0;
    m1_byteenable = 4'h0;
    s_waitrequest = 1'b0; s_readdata = 32'h0;
  endtask

  // Ends on a negedge with reset still high; the caller releases it.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    m0_read = 1'b1; m1_write = 1'b1;
    #1;
    nvec++; if (grant !== GNT_NONE) begin nerr++;
      $display("FAIL reset_grant: got %b want %b", grant, GNT_NONE); end
    nvec++; if ({s_read, s_write, s_address, s_byteenable} !== 38'h0) begin nerr++;
      $display("FAIL reset_s_outs: got rd=%b wr=%b a=%h be=%h want all 0",
               s_read, s_write, s_address, s_byteenable); end
    nvec++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin nerr++;
      $display("FAIL reset_wait: got %b%b want 11", m0_waitrequest, m1_waitrequest); end
  endtask

  task automatic test_single_read();
    do_reset();
    reset = 1'b0;
    m0_read = 1'b1; m0_address = MEM_BASE; m0_byteenable = 4'hF;
    s_waitrequest = 1'b0; s_readdata = 32'h3C1DA000;
    @(negedge clk);
    nvec++; if (grant !== GNT_NONE || s_read !== 1'b0 || m0_waitrequest !== 1'b1) begin nerr++;
      $display("FAIL read_cycle1_idle: got gnt=%b rd=%b w0=%b want 00 0 1",
               grant, s_read, m0_waitrequest); end
    @(negedge clk);
    nvec++; if (grant !== GNT_M0) begin nerr++;
      $display("FAIL read_grant: got %b want %b", grant, GNT_M0); end
    nvec++; if (s_read !== 1'b1 || s_address !== MEM_BASE) begin nerr++;
      $display("FAIL read_fwd: got rd=%b a=%h want 1 %h", s_read, s_address, MEM_BASE); end
    nvec++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin nerr++;
      $display("FAIL read_wait: got w0=%b w1=%b want 0 1", m0_waitrequest, m1_waitrequest); end
    nvec++; if (m0_readdata !== 32'h3C1DA000 || m1_readdata !== 32'h3C1DA000) begin nerr++;
      $display("FAIL read_data: got %h/%h want 3c1da000", m0_readdata, m1_readdata); end
    @(negedge clk);
    nvec++; if (grant !== GNT_NONE) begin nerr++;
      $display("FAIL read_back_idle: got %b want %b", grant, GNT_NONE); end
    clear_inputs();
  endtask

  task automatic test_tie();
    do_reset();
    reset = 1'b0;
    m0_read = 1'b1; m0_address = MEM_BASE;
    m1_write = 1'b1; m1_address = MEM_BASE + 32'h40; m1_writedata = 32'h12345678;
    m1_byteenable = 4'hF;
    @(negedge clk);
    @(negedge clk);
    nvec++; if (grant !== GNT_M0) begin nerr++;
      $display("FAIL tie_fair_first: got %b want %b", grant, GNT_M0); end
    nvec++; if (fp_grant !== GNT_M1) begin nerr++;
      $display("FAIL tie_fixed_first: got %b want %b", fp_grant, GNT_M1); end
    @(negedge clk);
    nvec++; if (grant !== GNT_M1 || s_write !== 1'b1 || s_address !== MEM_BASE + 32'h40) begin
      nerr++;
      $display("FAIL tie_fair_second: got gnt=%b wr=%b a=%h want 10 1 %h",
               grant, s_write, s_address, MEM_BASE + 32'h40); end
    m0_read = 1'b0;
    @(negedge clk);
    nvec++; if (grant !== GNT_NONE) begin nerr++;
      $display("FAIL tie_idle: got %b want %b", grant, GNT_NONE); end
    clear_inputs();
  endtask

  task automatic test_stall_write();
    int commits;
    commits = 0;
    do_reset();
    reset = 1'b0;
    m1_write = 1'b1; m1_address = MEM_BASE + 32'h100; m1_writedata = 32'hDEADBEEF;
    m1_byteenable = 4'b0011; s_waitrequest = 1'b1;
    @(negedge clk);
    nvec++; if (grant !== GNT_NONE) begin nerr++;
      $display("FAIL stall_first_edge: got %b want %b", grant, GNT_NONE); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m0_read = 1'b1; m0_address = MEM_BASE + 32'h8;
      s_waitrequest = (i < 3);
      #1;
      nvec++;
      if (grant !== GNT_M1 || s_write !== 1'b1 || s_read !== 1'b0 ||
          s_address !== MEM_BASE + 32'h100 || s_writedata !== 32'hDEADBEEF ||
          s_byteenable !== 4'b0011) begin
        nerr++;
        $display("FAIL stall_fwd[%0d]: got gnt=%b wr=%b rd=%b a=%h d=%h be=%b", i, grant,
                 s_write, s_read, s_address, s_writedata, s_byteenable);
      end
      nvec++;
      if (m0_waitrequest !== 1'b1 || m1_waitrequest !== (i < 3)) begin
        nerr++;
        $display("FAIL stall_wait[%0d]: got w0=%b w1=%b want 1 %b", i, m0_waitrequest,
                 m1_waitrequest, (i < 3));
      end
      if (s_write && !s_waitrequest) commits++;
    end
    @(negedge clk);
    m1_write = 1'b0;
    nvec++; if (commits !== 1) begin nerr++;
      $display("FAIL stall_commits: got %0d want 1", commits); end
    nvec++; if (grant !== GNT_M0) begin nerr++;
      $display("FAIL stall_then_m0: got %b want %b", grant, GNT_M0); end
    clear_inputs();
  endtask

  task automatic test_alternate();
    int c0, c1;
    logic [1:0] exp_gnt;
    c0 = 0; c1 = 0;
    do_reset();
    reset = 1'b0;
    m0_read = 1'b1; m0_address = MEM_BASE;
    m1_read = 1'b1; m1_address = MEM_BASE + 32'h200;
    s_waitrequest = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      exp_gnt = (k % 2 == 0) ? GNT_M0 : GNT_M1;
      nvec++; if (grant !== exp_gnt) begin nerr++;
        $display("FAIL alt_grant[%0d]: got %b want %b", k, grant, exp_gnt); end
      if (grant == GNT_M0 && !m0_waitrequest) c0++;
      if (grant == GNT_M1 && !m1_waitrequest) c1++;
    end
    nvec++; if (c0 !== 5 || c1 !== 5) begin nerr++;
      $display("FAIL alt_counts: got m0=%0d m1=%0d want 5 5", c0, c1); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    reset = 1'b0;
    m0_read = 1'b1; m0_address = MEM_BASE + 32'h4; s_waitrequest = 1'b1;
    @(negedge clk);
    @(negedge clk);
    nvec++; if (grant !== GNT_M0 || s_read !== 1'b1) begin nerr++;
      $display("FAIL mid_stalled: got gnt=%b rd=%b want 01 1", grant, s_read); end
    @(negedge clk);
    m0_address = MEM_BASE + 32'h8; m1_read = 1'b1; m1_address = MEM_BASE + 32'h300;
    #1;
    nvec++; if (s_address !== MEM_BASE + 32'h8 || grant !== GNT_M0) begin nerr++;
      $display("FAIL mid_addr_pass: got a=%h gnt=%b want %h 01", s_address, grant,
               MEM_BASE + 32'h8); end
    #2;
    reset = 1'b1;
    #1;
    nvec++; if (s_read !== 1'b0 || grant !== GNT_NONE || s_address !== 32'h0) begin nerr++;
      $display("FAIL mid_reset_outs: got rd=%b gnt=%b a=%h want 0 00 0", s_read, grant,
               s_address); end
    nvec++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin nerr++;
      $display("FAIL mid_reset_wait: got %b%b want 11", m0_waitrequest, m1_waitrequest); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    nvec++; if (grant !== GNT_NONE) begin nerr++;
      $display("FAIL mid_hold_off: got %b want %b", grant, GNT_NONE); end
    @(negedge clk);
    nvec++; if (grant !== GNT_M0) begin nerr++;
      $display("FAIL mid_tie_m0: got %b want %b", grant, GNT_M0); end
    clear_inputs();
  endtask

  task automatic test_abort();
    do_reset();
    reset = 1'b0;
    m0_read = 1'b1; m0_address = MEM_BASE + 32'h10; s_waitrequest = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nvec++; if (grant !== GNT_M0) begin nerr++;
      $display("FAIL abort_m0_own: got %b want %b", grant, GNT_M0); end
    m1_write = 1'b1; m1_address = MEM_BASE + 32'h500; m1_writedata = 32'hCAFEF00D;
    m1_byteenable = 4'hF;
    @(negedge clk);
    nvec++; if (grant !== GNT_M1) begin nerr++;
      $display("FAIL abort_m1_own: got %b want %b", grant, GNT_M1); end
    m0_read = 1'b0; s_waitrequest = 1'b1;
    @(negedge clk);
    nvec++; if (grant !== GNT_M1 || m1_waitrequest !== 1'b1) begin nerr++;
      $display("FAIL abort_m1_stall: got gnt=%b w1=%b want 10 1", grant, m1_waitrequest); end
    m1_write = 1'b0; m0_read = 1'b1;
    @(negedge clk);
    nvec++; if (grant !== GNT_NONE || m0_waitrequest !== 1'b1) begin nerr++;
      $display("FAIL abort_idle: got gnt=%b w0=%b want 00 1", grant, m0_waitrequest); end
    m1_write = 1'b1;
    @(negedge clk);
    // Last owner must still be M0 after the abort, so M1 wins this tie.
    nvec++; if (grant !== GNT_M1) begin nerr++;
      $display("FAIL abort_last_kept: got %b want %b", grant, GNT_M1); end
    s_waitrequest = 1'b0;
    @(negedge clk);
    nvec++; if (grant !== GNT_M0 || m0_waitrequest !== 1'b0) begin nerr++;
      $display("FAIL abort_m0_after: got gnt=%b w0=%b want 01 0", grant, m0_waitrequest); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_tie();
    test_stall_write();
    test_alternate();
    test_reset_mid();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
